serial_input_current_accumulator: RTL and testbench

SERIAL_INPUT_CURRENT_ACCUMULATOR -- requirements
Module: serial_input_current_accumulator

---
 rtl/snn_pkg.sv | 28 ++
 rtl/signed_saturator.sv | 55 +++++
 rtl/serial_input_current_accumulator.sv | 258 +++++++++++++++++++++++++
 tb/tb_serial_input_current_accumulator.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the spiking-neural-network datapath blocks.
//   - IDLE / ACCUM / DONE : state encoding of the serial current accumulator
//   - STATE_W              : width of that state encoding
//   - clog2()              : ceiling log2, usable in constant expressions
// -----------------------------------------------------------------------------
package snn_pkg;

   localparam int STATE_W = 2;

   localparam logic [STATE_W-1:0] IDLE  = 2'd0;
   localparam logic [STATE_W-1:0] ACCUM = 2'd1;
   localparam logic [STATE_W-1:0] DONE  = 2'd2;

   // Smallest r such that 2**r >= value (returns 0 for value <= 1).
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage : snn_pkg

// File: rtl/signed_saturator.sv
// -----------------------------------------------------------------------------
// signed_saturator
// Combinational clamp of a signed IN_W-bit value into the signed OUT_W-bit
// range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//
// Parameters
//   IN_W   : width of the signed input (must be greater than OUT_W)
//   OUT_W  : width of the signed, clamped output
//   SAT_EN : 1 = drive sat when clamping happens, 0 = sat tied low
//
// Ports
//   din  : in,  IN_W  - signed two's-complement value to clamp
//   dout : out, OUT_W - clamped signed value
//   sat  : out, 1     - high when din lay outside the OUT_W range
// -----------------------------------------------------------------------------
module signed_saturator #(
   parameter int IN_W   = 7,
   parameter int OUT_W  = 4,
   parameter bit SAT_EN = 1'b1
) (
   input  logic [IN_W-1:0]  din,
   output logic [OUT_W-1:0] dout,
   output logic             sat
);

   localparam int TOP_W = IN_W - OUT_W + 1;

   logic [TOP_W-1:0] top_bits_s;
   logic             sign_s;
   logic             fits_s;

   // The value fits when every bit from the output sign bit upward is a copy
   // of the input sign bit; otherwise the sign decides which rail to use.
   always_comb begin
      top_bits_s = din[IN_W-1:OUT_W-1];
      sign_s     = din[IN_W-1];
      fits_s     = (&top_bits_s) | ~(|top_bits_s);
      if (fits_s) begin
         dout = din[OUT_W-1:0];
      end else if (sign_s) begin
         dout = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
         dout = {1'b0, {(OUT_W-1){1'b1}}};
      end
   end

   generate
      if (SAT_EN) begin : g_sat
         assign sat = ~fits_s;
      end else begin : g_no_sat
         assign sat = 1'b0;
      end
   endgenerate

endmodule : signed_saturator

// File: rtl/serial_input_current_accumulator.sv
// -----------------------------------------------------------------------------
// serial_input_current_accumulator
// Serially sums the weights of the active synapses (one synapse per clock)
// and publishes the result, clamped to NBITS signed, as the neuron input
// current. A request snapshots spikes and weights, so the inputs are free to
// change once start has been accepted. Latency is fixed at M+1 clocks after
// the start edge, independent of the spike pattern.
//
// Optional feature macro: SNN_ICC_SAT_FLAG_EN
//   defined   : sat_flag is registered with each result (1 = value clamped)
//   undefined : sat_flag is tied low (the clamp itself is always present)
//
// Parameters
//   M     : number of synapses (>= 2)
//   NBITS : width of each signed weight and of input_current
//
// Ports
//   clk           : in,  1       - clock, rising edge
//   reset         : in,  1       - asynchronous active-high reset
//   start         : in,  1       - request one computation (honoured in IDLE)
//   input_spikes  : in,  M       - bit i high = synapse i spiked
//   weights       : in,  M*NBITS - weight i at [i*NBITS +: NBITS], signed
//   busy          : out, 1       - computation in progress (ACCUM or DONE)
//   done          : out, 1       - one-cycle pulse, new input_current valid
//   input_current : out, NBITS   - registered, saturated signed sum
//   sat_flag      : out, 1       - last result was clamped
// -----------------------------------------------------------------------------
module serial_input_current_accumulator
   import snn_pkg::*;
#(
   parameter int M     = 4,
   parameter int NBITS = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [M-1:0]       input_spikes,
   input  logic [M*NBITS-1:0] weights,
   output logic               busy,
   output logic               done,
   output logic [NBITS-1:0]   input_current,
   output logic               sat_flag
);

   // One guard bit above clog2(M) growth keeps the worst-case sum in range.
   localparam int ACC_W = NBITS + clog2(M) + 1;
   localparam int IDX_W = clog2(M);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(M - 1);

   logic [STATE_W-1:0] state_r;
   logic [STATE_W-1:0] next_state_s;

   logic               load_s;
   logic               accum_en_s;
   logic               finish_s;

   logic [M-1:0]       spikes_r;
   logic [NBITS-1:0]   weight_r [M];
   logic [IDX_W-1:0]   index_r;
   logic [ACC_W-1:0]   acc_r;

   logic [NBITS-1:0]   weight_sel_s;
   logic               spike_sel_s;
   logic [ACC_W-1:0]   addend_s;

   logic [NBITS-1:0]   clamped_s;

   logic               busy_r;
   logic               done_r;
   logic [NBITS-1:0]   current_r;

   // -------------------------------------------------------------------------
   // Control FSM
   // -------------------------------------------------------------------------

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode; DONE always returns to IDLE so a start seen there is
   // only acted on one cycle later.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               next_state_s = ACCUM;
            end else begin
               next_state_s = IDLE;
            end
         end
         ACCUM: begin
            if (index_r == LAST_IDX) begin
               next_state_s = DONE;
            end else begin
               next_state_s = ACCUM;
            end
         end
         DONE: begin
            next_state_s = IDLE;
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Per-state datapath controls.
   always_comb begin
      load_s     = 1'b0;
      accum_en_s = 1'b0;
      finish_s   = 1'b0;
      case (state_r)
         IDLE: begin
            load_s = start;
         end
         ACCUM: begin
            accum_en_s = 1'b1;
         end
         DONE: begin
            finish_s = 1'b1;
         end
         default: begin
            load_s     = 1'b0;
            accum_en_s = 1'b0;
            finish_s   = 1'b0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Snapshot and serial accumulation
   // -------------------------------------------------------------------------

   // Capture spikes and weights when a request is accepted; the accumulation
   // only ever reads these copies.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         spikes_r <= {M{1'b0}};
         for (int i = 0; i < M; i++) begin
            weight_r[i] <= {NBITS{1'b0}};
         end
      end else if (load_s) begin
         spikes_r <= input_spikes;
         for (int i = 0; i < M; i++) begin
            weight_r[i] <= weights[i*NBITS +: NBITS];
         end
      end else begin
         spikes_r <= spikes_r;
         for (int i = 0; i < M; i++) begin
            weight_r[i] <= weight_r[i];
         end
      end
   end

   // Select the current synapse and sign-extend its weight, or contribute
   // zero when that synapse did not spike.
   always_comb begin
      weight_sel_s = weight_r[index_r];
      spike_sel_s  = spikes_r[index_r];
      if (spike_sel_s) begin
         addend_s = {{(ACC_W-NBITS){weight_sel_s[NBITS-1]}}, weight_sel_s};
      end else begin
         addend_s = {ACC_W{1'b0}};
      end
   end

   // Synapse index and running sum.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         index_r <= {IDX_W{1'b0}};
         acc_r   <= {ACC_W{1'b0}};
      end else if (load_s) begin
         index_r <= {IDX_W{1'b0}};
         acc_r   <= {ACC_W{1'b0}};
      end else if (accum_en_s) begin
         index_r <= index_r + IDX_W'(1);
         acc_r   <= acc_r + addend_s;
      end else begin
         index_r <= index_r;
         acc_r   <= acc_r;
      end
   end

   // -------------------------------------------------------------------------
   // Clamp and result registers
   // -------------------------------------------------------------------------

`ifdef SNN_ICC_SAT_FLAG_EN
   logic sat_s;
   logic sat_flag_r;

   signed_saturator #(
      .IN_W   (ACC_W),
      .OUT_W  (NBITS),
      .SAT_EN (1'b1)
   ) u_saturator (
      .din  (acc_r),
      .dout (clamped_s),
      .sat  (sat_s)
   );

   // Clamp indication, refreshed only together with input_current.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sat_flag_r <= 1'b0;
      end else if (finish_s) begin
         sat_flag_r <= sat_s;
      end else begin
         sat_flag_r <= sat_flag_r;
      end
   end

   assign sat_flag = sat_flag_r;
`else
   logic sat_unused_s;

   signed_saturator #(
      .IN_W   (ACC_W),
      .OUT_W  (NBITS),
      .SAT_EN (1'b0)
   ) u_saturator (
      .din  (acc_r),
      .dout (clamped_s),
      .sat  (sat_unused_s)
   );

   assign sat_flag = 1'b0;
`endif

   // Result and status registers; done follows the DONE state by one edge so
   // it coincides with the new input_current value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         current_r <= {NBITS{1'b0}};
      end else begin
         busy_r <= (next_state_s != IDLE);
         done_r <= finish_s;
         if (finish_s) begin
            current_r <= clamped_s;
         end else begin
            current_r <= current_r;
         end
      end
   end

   assign busy          = busy_r;
   assign done          = done_r;
   assign input_current = current_r;

endmodule : serial_input_current_accumulator

// File: tb/tb_serial_input_current_accumulator.sv
// -----------------------------------------------------------------------------
// tb_serial_input_current_accumulator
// Self-checking bench for serial_input_current_accumulator (M=4, NBITS=4).
// A cycle-level reference model (request accepted -> result due M+1 edges
// later, sum computed with integer arithmetic from the captured inputs) is
// compared against every DUT output once per clock. Directed transactions
// pin the model with hand-computed results; a random phase follows.
// -----------------------------------------------------------------------------
module tb_serial_input_current_accumulator;

   localparam int M     = 4;
   localparam int NBITS = 4;
   localparam int LO    = -(1 <<< (NBITS - 1));
   localparam int HI    = (1 <<< (NBITS - 1)) - 1;
`ifdef SNN_ICC_SAT_FLAG_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   logic               clk;
   logic               reset;
   logic               start;
   logic [M-1:0]       input_spikes;
   logic [M*NBITS-1:0] weights;
   logic               busy;
   logic               done;
   logic [NBITS-1:0]   input_current;
   logic               sat_flag;

   int tests_run = 0;
   int tests_failed = 0;

   // reference model state
   int               m_phase = 0;   // 0 = idle, k = k edges since the start edge
   logic [NBITS-1:0] m_pend_cur = '0;
   bit               m_pend_sat = 1'b0;
   logic [NBITS-1:0] m_cur = '0;
   bit               m_sat = 1'b0;
   bit               m_done = 1'b0;

   serial_input_current_accumulator #(.M(M), .NBITS(NBITS)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .input_spikes  (input_spikes),
      .weights       (weights),
      .busy          (busy),
      .done          (done),
      .input_current (input_current),
      .sat_flag      (sat_flag)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // plain signed sum of the weights whose spike bit is set
   function automatic int weighted_sum(input logic [M-1:0] sp, input logic [M*NBITS-1:0] w);
      int s;
      int v;
      logic [NBITS-1:0] wi;
      s = 0;
      for (int i = 0; i < M; i++) begin
         wi = w[i*NBITS +: NBITS];
         v  = int'(wi);
         if (wi[NBITS-1]) v = v - (1 <<< NBITS);
         if (sp[i]) s = s + v;
      end
      return s;
   endfunction

   // advance the model by one rising edge using the inputs seen at that edge
   task automatic model_step();
      int s;
      int c;
      m_done = 1'b0;
      if (reset) begin
         m_phase = 0;
         m_cur   = '0;
         m_sat   = 1'b0;
      end else if (m_phase == 0) begin
         if (start) begin
            s = weighted_sum(input_spikes, weights);
            c = (s > HI) ? HI : ((s < LO) ? LO : s);
            m_pend_cur = c[NBITS-1:0];
            m_pend_sat = SAT_EN && (c != s);
            m_phase = 1;
         end
      end else if (m_phase < M + 1) begin
         m_phase++;
      end else begin
         m_phase = 0;
         m_cur   = m_pend_cur;
         m_sat   = m_pend_sat;
         m_done  = 1'b1;
      end
   endtask

   // compare process: every cycle, 1 time unit after the rising edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         model_step();
         check("done", done, m_done);
         check("busy", busy, (m_phase != 0));
         check("input_current", input_current, m_cur);
         check("sat_flag", sat_flag, m_sat);
      end
   end

   // one directed request; mode 1 = extra start during ACCUM,
   // mode 2 = inputs changed right after the start edge
   task automatic run_txn(input string name, input logic [M*NBITS-1:0] w,
                          input logic [M-1:0] sp, input logic [NBITS-1:0] exp_cur,
                          input bit exp_sat, input int mode);
      int got;
      int extra;
      @(negedge clk);
      weights      = w;
      input_spikes = sp;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (mode == 2) begin
         weights      = ~w;
         input_spikes = ~sp;
      end
      got = 0;
      for (int n = 1; n <= 20 && got == 0; n++) begin
         @(posedge clk);
         #2;
         if (done) got = n;
         if (mode == 1 && n == 2) start = 1'b1;
         if (mode == 1 && n == 3) start = 1'b0;
      end
      check({name, "_latency"}, got, M + 1);
      check({name, "_current"}, input_current, exp_cur);
      check({name, "_sat"}, sat_flag, SAT_EN && exp_sat);
      extra = 0;
      repeat (M + 3) begin
         @(posedge clk);
         #2;
         if (done) extra++;
      end
      check({name, "_single_done"}, extra, 0);
   endtask

   initial begin
      reset        = 1'b1;
      start        = 1'b0;
      input_spikes = '0;
      weights      = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_current", input_current, 0);
      check("reset_done", done, 0);
      reset = 1'b0;

      // {w3..w0} = {5,1,-2,3}, spikes 0101 -> 3 + 1 = 4
      run_txn("basic", 16'h51E3, 4'b0101, 4'b0100, 1'b0, 0);
      // 4 * 7 = 28 -> +7, clamped
      run_txn("pos_sat", 16'h7777, 4'b1111, 4'b0111, 1'b1, 0);
      // 4 * -8 = -32 -> -8, clamped
      run_txn("neg_sat", 16'h8888, 4'b1111, 4'b1000, 1'b1, 0);
      // no spikes -> 0, start pulsed again during ACCUM is ignored
      run_txn("no_spike", 16'h7777, 4'b0000, 4'b0000, 1'b0, 1);
      // spikes 1010 -> -2 + 5 = 3; inputs scrambled after the start edge
      run_txn("snapshot", 16'h51E3, 4'b1010, 4'b0011, 1'b0, 2);

      // reset while ACCUM is at index 2
      @(negedge clk);
      weights      = 16'h7777;
      input_spikes = 4'b1111;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_done", done, 0);
      check("abort_busy", busy, 0);
      check("abort_current", input_current, 0);
      check("abort_sat", sat_flag, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (M + 3) @(negedge clk);
      // 0 + 1 + 2 + 3 = 6
      run_txn("after_abort", 16'h3210, 4'b1111, 4'b0110, 1'b0, 0);

      // random phase, checked by the per-cycle compare process
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         reset        = ($urandom_range(0, 149) == 0);
         start        = ($urandom_range(0, 2) == 0);
         input_spikes = M'($urandom);
         weights      = (M*NBITS)'($urandom);
      end
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      repeat (M + 4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_serial_input_current_accumulator
